// File: rtl/layer_pkg.sv
// Shared constants and types for the layer BRAM arbiter.
// Defaults describe a 320x240 frame held in three 3-bit layer BRAMs.
package layer_pkg;

  localparam int unsigned LP_PIX_COUNT = 76800;
  localparam int unsigned LP_ADDR_W    = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  localparam logic [1:0] LAYER_NONE = 2'd0;
  localparam logic [1:0] LAYER_1    = 2'd1;
  localparam logic [1:0] LAYER_2    = 2'd2;
  localparam logic [1:0] LAYER_3    = 2'd3;

  function automatic logic [2:0] layer_onehot(
    input logic [1:0] layer
  );
    case (layer)
      LAYER_1: return 3'b001;
      LAYER_2: return 3'b010;
      LAYER_3: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/layer_clear_counter.sv
// Clear address counter; saturates at the last pixel
// and flags it so the clear FSM knows when to stop.
module layer_clear_counter
  import layer_pkg::*;
#(
  parameter int unsigned PIX_COUNT = LP_PIX_COUNT,
  parameter int unsigned ADDR_W    = LP_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIX_COUNT - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !last_o) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/layer_bram_arbiter.sv
// Shares one BRAM port among display scan, layer clear and brush.
// Scan wins while video_on; otherwise clear, then brush.
module layer_bram_arbiter
  import layer_pkg::*;
#(
  parameter int unsigned PIX_COUNT = LP_PIX_COUNT,
  parameter int unsigned ADDR_W    = LP_ADDR_W
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              video_on,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic              brush_req,
  input  logic [ADDR_W-1:0] brush_addr,
  input  logic [1:0]        brush_layer,
  input  logic [2:0]        brush_color,
  output logic              brush_ack,
  input  logic              clear_req,
  input  logic [2:0]        clear_mask,
  input  logic [2:0]        clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [2:0]        bram_din,
  output logic [2:0]        bram_we
);

  arb_state_e state_q, state_d;
  logic [2:0] mask_q, mask_d;
  logic [2:0] color_q, color_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        din_q, din_d;
  logic [2:0]        we_q, we_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] cnt;
  logic              cnt_last;
  logic              cnt_clr;
  logic              cnt_en;
  logic              clr_wr;
  logic              br_wr;
  logic              br_in_range;

  layer_clear_counter #(
    .PIX_COUNT (PIX_COUNT),
    .ADDR_W    (ADDR_W)
  ) u_cnt (
    .clk_i   (clk_100MHz),
    .rst_n_i (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .cnt_o   (cnt),
    .last_o  (cnt_last)
  );

  assign clr_wr = (state_q == ST_CLEAR) && !video_on
               && (mask_q != 3'b000);
  assign br_wr  = (state_q != ST_CLEAR) && !video_on
               && brush_req;
  assign br_in_range =
    ({1'b0, brush_addr} < (ADDR_W+1)'(PIX_COUNT));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    color_d = color_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          mask_d  = clear_mask;
          color_d = clear_color;
          cnt_clr = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (mask_q == 3'b000) begin
          state_d = ST_DONE;
        end else if (!video_on) begin
          cnt_en = 1'b1;
          if (cnt_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d = scan_addr;
    din_d  = 3'b000;
    we_d   = 3'b000;
    ack_d  = 1'b0;
    busy_d = (state_q == ST_CLEAR);
    done_d = (state_q == ST_DONE);
    unique case (1'b1)
      clr_wr: begin
        addr_d = cnt;
        din_d  = color_q;
        we_d   = mask_q;
      end
      br_wr: begin
        // out-of-range brush is acked but never reaches the pins
        addr_d = br_in_range ? brush_addr : '0;
        din_d  = brush_color;
        we_d   = br_in_range ? layer_onehot(brush_layer)
                             : 3'b000;
        ack_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= 3'b000;
      color_q <= 3'b000;
      addr_q  <= '0;
      din_q   <= 3'b000;
      we_q    <= 3'b000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign bram_we    = we_q;
  assign brush_ack  = ack_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_layer_bram_arbiter.sv
// Directed bench for layer_bram_arbiter with a 16-pixel layer.
// Inputs change 1ns after a rising edge; outputs are read there too.
module tb_layer_bram_arbiter;
  import layer_pkg::*;

  localparam int PC = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          video_on = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic          brush_req = 1'b0;
  logic [AW-1:0] brush_addr = '0;
  logic [1:0]    brush_layer = 2'd0;
  logic [2:0]    brush_color = 3'd0;
  logic          brush_ack;
  logic          clear_req = 1'b0;
  logic [2:0]    clear_mask = 3'd0;
  logic [2:0]    clear_color = 3'd0;
  logic          clear_busy;
  logic          clear_done;
  logic [AW-1:0] bram_addr;
  logic [2:0]    bram_din;
  logic [2:0]    bram_we;

  int errors = 0;
  int checks = 0;

  layer_bram_arbiter #(
    .PIX_COUNT (PC),
    .ADDR_W    (AW)
  ) dut (
    .clk_100MHz  (clk),
    .reset_n     (reset_n),
    .video_on    (video_on),
    .scan_addr   (scan_addr),
    .brush_req   (brush_req),
    .brush_addr  (brush_addr),
    .brush_layer (brush_layer),
    .brush_color (brush_color),
    .brush_ack   (brush_ack),
    .clear_req   (clear_req),
    .clear_mask  (clear_mask),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .bram_we     (bram_we)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_clear(input logic [2:0] m,
                             input logic [2:0] c);
    clear_req   = 1'b1;
    clear_mask  = m;
    clear_color = c;
    tick();
    clear_req   = 1'b0;
    clear_mask  = 3'd0;
    clear_color = 3'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bram_addr, bram_din, bram_we, brush_ack, clear_busy,
         clear_done} !== '0) begin
      errors++;
      $display("FAIL reset_init: addr=%0h din=%0b we=%0b ack=%0b busy=%0b done=%0b want all 0",
               bram_addr, bram_din, bram_we, brush_ack,
               clear_busy, clear_done);
    end
    reset_n = 1'b1;
    scan_addr = 8'h21;
    tick();
    checks++;
    if (bram_addr !== 8'h21 || bram_we !== 3'b000) begin
      errors++;
      $display("FAIL idle_scan: addr=%0h we=%0b want 21/000",
               bram_addr, bram_we);
    end
  endtask

  task automatic test_brush();
    brush_req = 1'b1;
    brush_addr = 8'd5;
    brush_layer = 2'd1;
    brush_color = 3'b011;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bram_addr, bram_din, bram_we, brush_ack} !==
          {8'd5, 3'b011, 3'b001, 1'b1}) begin
        errors++;
        $display("FAIL brush_l1[%0d]: addr=%0d din=%0b we=%0b ack=%0b want 5/011/001/1",
                 i, bram_addr, bram_din, bram_we, brush_ack);
      end
    end
    brush_layer = 2'd3;
    tick();
    checks++;
    if (bram_we !== 3'b100 || brush_ack !== 1'b1) begin
      errors++;
      $display("FAIL brush_l3: we=%0b ack=%0b want 100/1",
               bram_we, brush_ack);
    end
    video_on = 1'b1;
    scan_addr = 8'h33;
    tick();
    checks++;
    if ({bram_addr, bram_we, brush_ack} !==
        {8'h33, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL brush_vid: addr=%0h we=%0b ack=%0b want 33/000/0",
               bram_addr, bram_we, brush_ack);
    end
    video_on = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bram_addr, bram_din, bram_we, brush_ack, clear_busy,
         clear_done} !== '0 || dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid: addr=%0h we=%0b ack=%0b st=%0d want zeros/IDLE",
               bram_addr, bram_we, brush_ack, dut.state_q);
    end
    reset_n = 1'b1;
    brush_req = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    start_clear(3'b101, 3'b111);
    for (int i = 0; i < PC; i++) begin
      tick();
      checks++;
      if ({bram_addr, bram_din, bram_we, clear_busy,
           clear_done} !==
          {AW'(i), 3'b111, 3'b101, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL clear_wr[%0d]: addr=%0d din=%0b we=%0b busy=%0b done=%0b",
                 i, bram_addr, bram_din, bram_we, clear_busy,
                 clear_done);
      end
    end
    tick();
    checks++;
    if ({clear_done, clear_busy, bram_we} !==
        {1'b1, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL clear_done: done=%0b busy=%0b we=%0b want 1/0/000",
               clear_done, clear_busy, bram_we);
    end
    tick();
    checks++;
    if (clear_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_once: done=%0b want 0",
               clear_done);
    end
  endtask

  task automatic test_preempt();
    int exp_a;
    start_clear(3'b011, 3'b010);
    exp_a = 0;
    for (int c = 0; c < PC + 5; c++) begin
      video_on = (c >= 7 && c < 12);
      scan_addr = 8'h40 + 8'(c);
      tick();
      checks++;
      if (video_on) begin
        if (bram_we !== 3'b000 || bram_addr !== scan_addr) begin
          errors++;
          $display("FAIL preempt_scan[%0d]: addr=%0h we=%0b want %0h/000",
                   c, bram_addr, bram_we, scan_addr);
        end
      end else begin
        if (bram_we !== 3'b011 || bram_addr !== AW'(exp_a)) begin
          errors++;
          $display("FAIL preempt_wr[%0d]: addr=%0d we=%0b want %0d/011",
                   c, bram_addr, bram_we, exp_a);
        end
        exp_a++;
      end
    end
    video_on = 1'b0;
    tick();
    checks++;
    if (clear_done !== 1'b1) begin
      errors++;
      $display("FAIL preempt_done: done=%0b want 1", clear_done);
    end
    tick();
  endtask

  task automatic test_brush_blocked();
    start_clear(3'b001, 3'b000);
    brush_req = 1'b1;
    brush_addr = 8'd9;
    brush_layer = 2'd2;
    brush_color = 3'b100;
    for (int i = 0; i < PC; i++) begin
      tick();
      checks++;
      if (brush_ack !== 1'b0 || bram_we !== 3'b001) begin
        errors++;
        $display("FAIL blocked_ack[%0d]: ack=%0b we=%0b want 0/001",
                 i, brush_ack, bram_we);
      end
    end
    tick();
    checks++;
    if ({bram_addr, bram_din, bram_we, brush_ack, clear_done} !==
        {8'd9, 3'b100, 3'b010, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL blocked_grant: addr=%0d din=%0b we=%0b ack=%0b done=%0b",
               bram_addr, bram_din, bram_we, brush_ack, clear_done);
    end
    brush_req = 1'b0;
    tick();
    checks++;
    if (brush_ack !== 1'b0 || bram_we !== 3'b000) begin
      errors++;
      $display("FAIL blocked_release: ack=%0b we=%0b want 0/000",
               brush_ack, bram_we);
    end
  endtask

  task automatic test_zero_mask();
    start_clear(3'b000, 3'b111);
    tick();
    checks++;
    if ({clear_busy, clear_done, bram_we} !==
        {1'b1, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL zero_c1: busy=%0b done=%0b we=%0b want 1/0/000",
               clear_busy, clear_done, bram_we);
    end
    start_clear(3'b111, 3'b111);
    checks++;
    if ({clear_done, clear_busy, bram_we} !==
        {1'b1, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL zero_done: done=%0b busy=%0b we=%0b want 1/0/000",
               clear_done, clear_busy, bram_we);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({clear_done, clear_busy, bram_we} !== 5'b0) begin
        errors++;
        $display("FAIL zero_ignored[%0d]: done=%0b busy=%0b we=%0b want 0",
                 i, clear_done, clear_busy, bram_we);
      end
    end
  endtask

  task automatic test_abort();
    int bad;
    start_clear(3'b111, 3'b010);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bram_addr !== 8'd3 || bram_we !== 3'b111) begin
      errors++;
      $display("FAIL abort_pre: addr=%0d we=%0b want 3/111",
               bram_addr, bram_we);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < PC + 4; i++) begin
      tick();
      if (bram_we !== 3'b000 || clear_done !== 1'b0
          || clear_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d active cycles want 0", bad);
    end
    brush_req = 1'b1;
    brush_addr = 8'd3;
    brush_layer = 2'd0;
    tick();
    checks++;
    if ({bram_addr, bram_we, brush_ack} !==
        {8'd3, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL abort_l0: addr=%0d we=%0b ack=%0b want 3/000/1",
               bram_addr, bram_we, brush_ack);
    end
    brush_addr = 8'd20;
    brush_layer = 2'd1;
    tick();
    checks++;
    if (bram_we !== 3'b000 || brush_ack !== 1'b1
        || bram_addr >= AW'(PC)) begin
      errors++;
      $display("FAIL brush_oor: addr=%0d we=%0b ack=%0b want <16/000/1",
               bram_addr, bram_we, brush_ack);
    end
    brush_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_brush();
    test_clear();
    test_preempt();
    test_brush_blocked();
    test_zero_mask();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
